// File: rtl/dmem_timer_responder.sv
// Memory-mapped timer peripheral on the data-memory load/store port.
// Prescaled 32-bit up-counter with compare, optional auto-reload,
// sticky match flag (write-1-to-clear) and an interrupt output.
// Register map by addr[3:2]: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
// PRESCALE_W must not exceed 24 so the prescale field fits in CTRL.
module dmem_timer_responder #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  wren,
  input  logic [11:0]           addr,
  input  logic [31:0]           dataIn,
  input  logic [2:0]            access_type,
  output logic [31:0]           dataOut,
  output logic                  irq
);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // Byte-lane enables for a store; reserved encodings write nothing.
  function automatic logic [3:0] lane_enable(input logic [2:0] at, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (at)
      3'b000, 3'b100: be = 4'b0001 << lane;
      3'b001, 3'b101: be = lane[1] ? 4'b1100 : 4'b0011;
      3'b010:         be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data onto every lane it may land in.
  function automatic logic [31:0] replicate_store(input logic [2:0] at, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (at)
      3'b000, 3'b100: r = {4{d[7:0]}};
      3'b001, 3'b101: r = {2{d[15:0]}};
      default:        r = d;
    endcase
    return r;
  endfunction

  // Keep unwritten lanes of the old value, take written lanes from new data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

  // Shift the addressed lane to bit 0 and sign/zero extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] at,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (at)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  logic                  enable_r;
  logic                  auto_reload_r;
  logic                  irq_en_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [PRESCALE_W-1:0] pre_r;
  logic [31:0]           count_r;
  logic [31:0]           compare_r;
  logic                  flag_r;
  logic [31:0]           data_out_r;

  logic [31:0]           ctrl_word_s;
  logic [31:0]           read_word_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_s;
  logic [31:0]           merged_s;
  logic                  wr_s;
  logic                  tick_s;
  logic                  match_s;
  logic                  unused_s;

  assign wr_s     = sel & wren;
  assign be_s     = lane_enable(access_type, addr[1:0]);
  assign wdata_s  = replicate_store(access_type, dataIn);
  assign tick_s   = enable_r & (pre_r == prescale_r);
  assign match_s  = (count_r == compare_r);
  assign unused_s = ^addr[11:4];

  // Assemble CTRL readback and select the addressed register.
  always_comb begin
    ctrl_word_s                   = 32'h0000_0000;
    ctrl_word_s[0]                = enable_r;
    ctrl_word_s[1]                = auto_reload_r;
    ctrl_word_s[2]                = irq_en_r;
    ctrl_word_s[8 +: PRESCALE_W]  = prescale_r;
    case (addr[3:2])
      REG_CTRL:    read_word_s = ctrl_word_s;
      REG_COUNT:   read_word_s = count_r;
      REG_COMPARE: read_word_s = compare_r;
      REG_STATUS:  read_word_s = {31'h0000_0000, flag_r};
      default:     read_word_s = 32'h0000_0000;
    endcase
    merged_s = merge_lanes(read_word_s, wdata_s, be_s);
  end

  // Control register: merged store updates fields; other bits are not stored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_r      <= 1'b0;
      auto_reload_r <= 1'b0;
      irq_en_r      <= 1'b0;
      prescale_r    <= {PRESCALE_W{1'b0}};
    end else if (wr_s && addr[3:2] == REG_CTRL) begin
      enable_r      <= merged_s[0];
      auto_reload_r <= merged_s[1];
      irq_en_r      <= merged_s[2];
      prescale_r    <= merged_s[8 +: PRESCALE_W];
    end else begin
      enable_r      <= enable_r;
      auto_reload_r <= auto_reload_r;
      irq_en_r      <= irq_en_r;
      prescale_r    <= prescale_r;
    end
  end

  // Prescaler: counts while enabled, returns to 0 on tick, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_r <= {PRESCALE_W{1'b0}};
    end else if (tick_s) begin
      pre_r <= {PRESCALE_W{1'b0}};
    end else if (enable_r) begin
      pre_r <= pre_r + PRESCALE_W'(1);
    end else begin
      pre_r <= pre_r;
    end
  end

  // Counter: a store beats the tick; on match reload to 0 if auto-reload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= 32'h0000_0000;
    end else if (wr_s && addr[3:2] == REG_COUNT) begin
      count_r <= merged_s;
    end else if (tick_s && match_s && auto_reload_r) begin
      count_r <= 32'h0000_0000;
    end else if (tick_s) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Compare register; the match in the same cycle uses the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      compare_r <= 32'h0000_0000;
    end else if (wr_s && addr[3:2] == REG_COMPARE) begin
      compare_r <= merged_s;
    end else begin
      compare_r <= compare_r;
    end
  end

  // Sticky match flag: set has priority over write-1-to-clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_r <= 1'b0;
    end else if (tick_s && match_s) begin
      flag_r <= 1'b1;
    end else if (wr_s && addr[3:2] == REG_STATUS && be_s[0] && wdata_s[0]) begin
      flag_r <= 1'b0;
    end else begin
      flag_r <= flag_r;
    end
  end

  // Load data: captured from pre-update register values, held otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_r <= 32'h0000_0000;
    end else if (sel && !wren) begin
      data_out_r <= load_extract(read_word_s, access_type, addr[1:0]);
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign dataOut = data_out_r;
  assign irq     = flag_r & irq_en_r;

endmodule

// File: tb/tb_dmem_timer_responder.sv
// Scoreboard bench for dmem_timer_responder: loads push expected data/irq,
// a monitor pops and compares one cycle after each load edge.
module tb_dmem_timer_responder;

  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_CNT  = 12'h004;
  localparam logic [11:0] A_CMP  = 12'h008;
  localparam logic [11:0] A_STAT = 12'h00C;
  localparam logic [2:0]  T_B    = 3'b000;
  localparam logic [2:0]  T_H    = 3'b001;
  localparam logic [2:0]  T_W    = 3'b010;
  localparam logic [2:0]  T_RSV  = 3'b011;
  localparam logic [2:0]  T_BU   = 3'b100;
  localparam logic [2:0]  T_HU   = 3'b101;

  logic        clock;
  logic        reset;
  logic        sel;
  logic        wren;
  logic [11:0] addr;
  logic [31:0] dataIn;
  logic [2:0]  access_type;
  logic [31:0] dataOut;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic ld_vld;
  logic done;

  dmem_timer_responder #(.PRESCALE_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .sel         (sel),
    .wren        (wren),
    .addr        (addr),
    .dataIn      (dataIn),
    .access_type (access_type),
    .dataOut     (dataOut),
    .irq         (irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Marks the cycle after a load edge, when dataOut carries the result.
  always @(posedge clock or posedge reset) begin
    if (reset) ld_vld <= 1'b0;
    else       ld_vld <= sel & ~wren;
  end

  // Monitor: reset-value checks, scoreboard pops, final summary.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        checks += 2;
        if (dataOut !== 32'h0000_0000) begin
          errors++;
          $display("FAIL reset_dataOut: got %h expected 00000000", dataOut);
        end
        if (irq !== 1'b0) begin
          errors++;
          $display("FAIL reset_irq: got %b expected 0", irq);
        end
      end else if (ld_vld) begin
        checks += 2;
        if (sb.size() == 0) begin
          errors += 2;
          $display("FAIL unexpected_load: got %h expected no load result", dataOut);
        end else begin
          e = sb.pop_front();
          if (dataOut !== e.data) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", e.name, dataOut, e.data);
          end
          if (irq !== e.irq) begin
            errors++;
            $display("FAIL %s irq: got %b expected %b", e.name, irq, e.irq);
          end
        end
      end
      if (done) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL leftover_expectations: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic access(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [2:0] t);
    @(negedge clock);
    sel = 1'b1; wren = w; addr = a; dataIn = d; access_type = t;
    @(posedge clock);
    #1;
    sel = 1'b0; wren = 1'b0;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d, input logic [2:0] t);
    access(1'b1, a, d, t);
  endtask

  task automatic load(input logic [11:0] a, input logic [2:0] t, input logic [31:0] exp_d,
                      input logic exp_irq, input string name);
    exp_t e;
    e.name = name; e.data = exp_d; e.irq = exp_irq;
    sb.push_back(e);
    access(1'b0, a, 32'h0000_0000, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sel = 1'b0;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin : driver
    reset = 1'b1; done = 1'b0;
    sel = 1'b0; wren = 1'b0; addr = 12'h000; dataIn = 32'h0000_0000; access_type = T_W;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;

    // Reset values of all registers
    load(A_CTRL, T_W, 32'h0000_0000, 1'b0, "rst_ctrl");
    load(A_CNT,  T_W, 32'h0000_0000, 1'b0, "rst_count");
    load(A_CMP,  T_W, 32'h0000_0000, 1'b0, "rst_compare");
    load(A_STAT, T_W, 32'h0000_0000, 1'b0, "rst_status");

    // Prescale 0, auto-reload at COMPARE=3, irq enabled
    store(A_CMP, 32'h0000_0003, T_W);
    store(A_CTRL, 32'h0000_0007, T_W);
    load(A_CNT, T_W, 32'h0000_0000, 1'b0, "ar_cnt0");
    load(A_CNT, T_W, 32'h0000_0001, 1'b0, "ar_cnt1");
    load(A_CNT, T_W, 32'h0000_0002, 1'b0, "ar_cnt2");
    load(A_CNT, T_W, 32'h0000_0003, 1'b1, "ar_cnt3_match");
    load(A_CNT, T_W, 32'h0000_0000, 1'b1, "ar_reload0");
    store(A_STAT, 32'h0000_0001, T_W);
    load(A_STAT, T_W, 32'h0000_0000, 1'b0, "w1c_cleared");
    load(A_CNT,  T_W, 32'h0000_0003, 1'b1, "ar_second_match");
    load(A_STAT, T_W, 32'h0000_0001, 1'b1, "flag_set_again");
    load(A_CNT,  T_W, 32'h0000_0001, 1'b1, "ar_cnt1b");
    load(A_CNT,  T_W, 32'h0000_0002, 1'b1, "ar_cnt2b");
    store(A_STAT, 32'h0000_0001, T_W);
    load(A_STAT, T_W, 32'h0000_0001, 1'b1, "w1c_vs_match_set_wins");
    store(A_CTRL, 32'h0000_0000, T_W);
    load(A_STAT, T_W, 32'h0000_0001, 1'b0, "irq_en_off");
    store(A_STAT, 32'h0000_0001, T_W);
    load(A_CNT,  T_W, 32'h0000_0002, 1'b0, "disable_tick_applies");

    // Prescale 2, wrap through 0xFFFFFFFF
    store(A_CMP, 32'hFFFF_FFFF, T_W);
    store(A_CNT, 32'hFFFF_FFFE, T_W);
    store(A_CTRL, 32'h0000_0201, T_W);
    load(A_CNT,  T_W, 32'hFFFF_FFFE, 1'b0, "ps_hold_a");
    load(A_CTRL, T_W, 32'h0000_0201, 1'b0, "ps_ctrl_readback");
    load(A_CNT,  T_W, 32'hFFFF_FFFE, 1'b0, "ps_tick_edge");
    load(A_CNT,  T_W, 32'hFFFF_FFFF, 1'b0, "ps_after_tick");
    idle(1);
    load(A_CNT,  T_W, 32'hFFFF_FFFF, 1'b0, "ps_match_edge");
    load(A_CNT,  T_W, 32'h0000_0000, 1'b0, "ps_wrapped");
    load(A_STAT, T_W, 32'h0000_0001, 1'b0, "ps_flag");

    // Sub-word accesses on COUNT while disabled
    store(A_CTRL, 32'h0000_0000, T_W);
    store(A_STAT, 32'h0000_0001, T_W);
    store(A_CNT,  32'h0000_0000, T_W);
    store(12'h005, 32'h0000_0080, T_B);
    load(A_CNT,   T_W,  32'h0000_8000, 1'b0, "sb_word");
    load(12'h005, T_B,  32'hFFFF_FF80, 1'b0, "lb_signed");
    load(12'h005, T_BU, 32'h0000_0080, 1'b0, "lbu");
    store(12'h006, 32'h0000_BEEF, T_H);
    load(A_CNT,   T_W,  32'hBEEF_8000, 1'b0, "sh_word");
    load(12'h006, T_H,  32'hFFFF_BEEF, 1'b0, "lh_signed");
    load(12'h007, T_HU, 32'h0000_BEEF, 1'b0, "lhu_addr0_ignored");

    // Store-vs-tick collision and reserved access types
    store(A_CTRL, 32'h0000_0001, T_W);
    store(A_CNT,  32'h0000_0100, T_W);
    load(A_CNT,  T_W,   32'h0000_0100, 1'b0, "store_beats_tick");
    store(A_CMP, 32'h1234_5678, T_RSV);
    load(A_CMP,  T_W,   32'hFFFF_FFFF, 1'b0, "rsv_store_ignored");
    load(A_CNT,  T_RSV, 32'h0000_0000, 1'b0, "rsv_load_zero");
    load(A_CNT,  T_W,   32'h0000_0104, 1'b0, "count_resumed");
    load(A_CTRL, T_W,   32'h0000_0001, 1'b0, "ctrl_enable_only");

    // Asynchronous reset mid-count with flag set
    store(A_CMP,  32'h0000_0005, T_W);
    store(A_CNT,  32'h0000_0000, T_W);
    store(A_CTRL, 32'h0000_0007, T_W);
    idle(8);
    load(A_STAT, T_W, 32'h0000_0001, 1'b1, "pre_reset_flag");
    idle(1);
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    idle(3);
    load(A_CNT,  T_W, 32'h0000_0000, 1'b0, "post_reset_stopped");
    load(A_CTRL, T_W, 32'h0000_0000, 1'b0, "post_reset_ctrl");
    load(A_STAT, T_W, 32'h0000_0000, 1'b0, "post_reset_status");
    idle(1);
    done = 1'b1;
    forever @(negedge clock);
  end

endmodule

// File: doc/dmem_timer_responder.md
# dmem_timer_responder

Memory-mapped timer peripheral that sits on the processor's data-memory port beside the data RAM and answers the same load/store interface: `wren`, 12-bit address, 32-bit write data, 3-bit `access_type`, and registered read data. It holds a prescaled 32-bit up-counter with a compare register, an optional auto-reload, a sticky match flag and an interrupt line. The top level decodes the address region and drives `sel`. Read data is steered between RAM and this block one cycle later.

## Interface
Parameters:
- PRESCALE_W, 8, width of the prescale field and of the internal prescale counter

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- sel  in  1  access targets this block this cycle
- wren  in  1  1 = store, 0 = load (valid only with sel)
- addr  in  12  byte address; addr[3:2] selects register, addr[1:0] selects byte lane
- dataIn  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- access_type  in  3  funct3 encoding: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; others reserved
- dataOut  out  32  registered load data, sign- or zero-extended
- irq  out  1  match flag AND irq-enable

## Operation
- Register map (addr[3:2]):
  - 0 CTRL: [0] enable, [1] auto_reload, [2] irq_en, [8+PRESCALE_W-1:8] prescale. Other bits read 0.
  - 1 COUNT
  - 2 COMPARE
  - 3 STATUS: [0] match flag, write-1-to-clear
- Stores (sel & wren):
  - Byte: writes lane addr[1:0].
  - Half: writes lane addr[1] (addr[0] ignored).
  - Word: writes all lanes (addr[1:0] ignored).
  - Unwritten lanes are kept.
  - Reserved access_type: store ignored.
- Loads (sel & !wren):
  - The selected lane is shifted to bit 0.
  - Byte and half are sign-extended for 000/001 and zero-extended for 100/101.
  - Reserved access_type returns 0.
- Prescaler:
  - While enable=1, pre increments each cycle.
  - tick = (pre == prescale). On tick, pre returns to 0.
  - prescale=0 gives a tick every cycle.
  - While enable=0, pre and COUNT hold.
- On tick:
  - If COUNT == COMPARE: flag is set. COUNT becomes 0 if auto_reload, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1, wrapping modulo 2^32 (0xFFFFFFFF → 0).
- `irq` is combinational: flag & irq_en.

## Timing
- Reset (async, any time, including mid-count): CTRL, COUNT, COMPARE, pre, flag and dataOut all go to 0; irq goes to 0.
- Store takes effect at the rising edge where sel & wren. The new value is visible to a load issued the next cycle.
- Load latency is 1 cycle:
  - dataOut is captured at the edge where sel & !wren, from register values before that edge's update.
  - dataOut holds its last value when there is no load.
- Simultaneous events at one edge:
  - Store to COUNT and tick: the store wins, the increment is discarded, and pre resets to 0.
  - W1C to STATUS and match: set wins, so flag stays 1.
  - Store to COMPARE and tick: the match compares against the old COMPARE.
  - Store clearing enable and tick: the tick in that cycle still applies; counting stops afterwards.
  - Store to CTRL changing prescale: pre is not reset. If pre > new prescale, counting continues until pre wraps modulo 2^PRESCALE_W.
- irq follows the flag and irq_en with no added latency, same cycle as they are registered.

## Test plan
- Reset then load all four registers (word) → dataOut 0 each, one cycle after each load; irq 0.
- SW COMPARE=3, SW CTRL=0x0000_0007 (prescale 0, enable, auto_reload, irq_en) →
  - COUNT reads 0,1,2,3,0,1…
  - flag and irq assert at the edge where COUNT goes 3→0.
  - SW STATUS=1 clears both unless a match occurs in the same cycle.
- SW CTRL=0x0000_0201 (prescale 2, enable), COMPARE=0xFFFF_FFFF → COUNT increments every 3rd cycle. Set COUNT=0xFFFF_FFFE, then on the next tick COUNT=0xFFFF_FFFF; on the following tick COUNT=0 and flag=1.
- Sub-word:
  - SW COUNT=0 while disabled.
  - SB 0x80 at COUNT+1 → word reads 0x0000_8000.
  - LB at COUNT+1 → 0xFFFF_FF80; LBU → 0x0000_0080.
  - SH 0xBEEF at COUNT+2 → word 0xBEEF_8000; LH at +2 → 0xFFFF_BEEF.
- Collision: while ticking every cycle, SW COUNT=0x100 → next read 0x100 exactly (no +1). A reserved access_type (011) store to COMPARE leaves it unchanged; a 011 load returns 0.
- Assert reset asynchronously between clock edges while counting with flag=1 → all outputs 0 immediately; after release, counter stays stopped (enable=0).
